// File: rtl/hs_sync_rx_ctrl.sv
// ----------------------------------------------------------------------------
// hs_sync_rx_ctrl
//
// Receive-side controller for a 4-phase req/ack clock-domain crossing.
// The source raises un_sync_req with un_sync_bus already stable. This block
// passes the request level through a NUM_STAGES-deep synchronizer and then
// captures the (unsynchronized, but held-stable) data bus. It presents the
// word to the local consumer, and then answers with sync_ack. It waits for
// the request to drop before it lowers sync_ack and re-arms.
//
// Parameters
//   DATA_W      width of the crossing data bus
//   NUM_STAGES  synchronizer depth on un_sync_req (legal 2..4)
//   CNT_W       width of the completed-transfer counter (wraps)
//
// Ports
//   sync_Clk     in   destination-domain clock
//   sync_Rst     in   synchronous, active-high reset
//   un_sync_req  in   source request level (asynchronous)
//   un_sync_bus  in   source data, stable while un_sync_req=1
//   sync_ack     out  registered ack back to the source domain
//   sync_bus     out  captured data word
//   sync_valid   out  sync_bus holds an unconsumed word
//   sync_ready   in   consumer accepts the word
//   err_clr      in   clears proto_err on the next edge
//   proto_err    out  sticky: req dropped before the word was consumed
//   xfer_cnt     out  count of completed transfers, wraps at 2^CNT_W
//   dbg_state    out  current FSM state (IDLE=0, HOLD=1, ACK=2)
//
// Consumer handshake: a word transfers on the rising edge where
// sync_valid=1 and sync_ready=1. sync_valid stays high and sync_bus stays
// frozen until that edge, unless the source withdraws its request first.
// sync_ready is ignored whenever sync_valid is low.
// ----------------------------------------------------------------------------
module hs_sync_rx_ctrl #(
    parameter int DATA_W     = 8,
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 8
) (
    input  logic              sync_Clk,
    input  logic              sync_Rst,
    input  logic              un_sync_req,
    input  logic [DATA_W-1:0] un_sync_bus,
    output logic              sync_ack,
    output logic [DATA_W-1:0] sync_bus,
    output logic              sync_valid,
    input  logic              sync_ready,
    input  logic              err_clr,
    output logic              proto_err,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [NUM_STAGES-1:0] req_chain;
    logic                  req_s;
    logic [1:0]            state;

    // Request synchronizer. Bit 0 is the metastability-catching flop. req_s
    // is the last stage, so a rising request is visible after NUM_STAGES
    // edges.
    always_ff @(posedge sync_Clk) begin
        if (sync_Rst) begin
            req_chain <= '0;
        end else begin
            req_chain <= {req_chain[NUM_STAGES-2:0], un_sync_req};
        end
    end

    assign req_s     = req_chain[NUM_STAGES-1];
    assign dbg_state = state;

    always_ff @(posedge sync_Clk) begin
        if (sync_Rst) begin
            state      <= ST_IDLE;
            sync_ack   <= 1'b0;
            sync_bus   <= '0;
            sync_valid <= 1'b0;
            proto_err  <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            // The clear is written first so that a protocol-error set
            // further down in the same edge overrides it.
            if (err_clr) begin
                proto_err <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    // IDLE is only entered with req_s low. Any high req_s
                    // seen here is therefore a fresh request, never a
                    // request left over from the previous word.
                    if (req_s) begin
                        sync_bus   <= un_sync_bus;
                        sync_valid <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    // Consumption wins over a simultaneous request drop.
                    if (sync_ready) begin
                        sync_valid <= 1'b0;
                        sync_ack   <= 1'b1;
                        xfer_cnt   <= xfer_cnt + CNT_W'(1);
                        state      <= ST_ACK;
                    end else if (!req_s) begin
                        // The source withdrew its request before the word
                        // was taken. Drop the word and send no ack.
                        sync_valid <= 1'b0;
                        proto_err  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                ST_ACK: begin
                    // Hold ack for as long as req is held; there is no
                    // timeout.
                    if (!req_s) begin
                        sync_ack <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: begin
                    sync_ack   <= 1'b0;
                    sync_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_sync_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hs_sync_rx_ctrl
//
// Drives the receive controller as a 4-phase source plus a consumer. The
// expected behaviour comes from the protocol rules:
//   - valid rises NUM_STAGES+1 edges after req is first sampled high
//   - ack falls NUM_STAGES+1 edges after req is first sampled low
//   - a proto error ends HOLD NUM_STAGES+1 edges after req is first
//     sampled low
//   - xfer_cnt is the number of consumed words modulo 2^CNT_W
// Words are tracked in an expected queue. Two instances share the same
// stimulus: one uses the default counter width, and one uses CNT_W=2 to
// show the counter wrapping.
// ----------------------------------------------------------------------------
module tb_hs_sync_rx_ctrl;

    localparam int DW = 8;
    localparam int NS = 2;
    localparam int TIMEOUT = 40;

    // ---------------- clock / reset ----------------
    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          req     = 1'b0;
    logic [DW-1:0] bus     = '0;
    logic          ready   = 1'b0;
    logic          err_clr = 1'b0;

    logic          ack,  valid,  perr;
    logic [DW-1:0] sbus;
    logic [7:0]    cnt;
    logic [1:0]    dbg;

    logic          ack2, valid2, perr2;
    logic [DW-1:0] sbus2;
    logic [1:0]    cnt2;
    logic [1:0]    dbg2;

    always #5 clk = ~clk;

    hs_sync_rx_ctrl #(.DATA_W(DW), .NUM_STAGES(NS), .CNT_W(8)) dut (
        .sync_Clk(clk), .sync_Rst(rst), .un_sync_req(req), .un_sync_bus(bus),
        .sync_ack(ack), .sync_bus(sbus), .sync_valid(valid), .sync_ready(ready),
        .err_clr(err_clr), .proto_err(perr), .xfer_cnt(cnt), .dbg_state(dbg)
    );

    hs_sync_rx_ctrl #(.DATA_W(DW), .NUM_STAGES(NS), .CNT_W(2)) dut_w2 (
        .sync_Clk(clk), .sync_Rst(rst), .un_sync_req(req), .un_sync_bus(bus),
        .sync_ack(ack2), .sync_bus(sbus2), .sync_valid(valid2), .sync_ready(ready),
        .err_clr(err_clr), .proto_err(perr2), .xfer_cnt(cnt2), .dbg_state(dbg2)
    );

    // ---------------- scoreboard state ----------------
    int            pass_cnt = 0;
    int            total_cnt = 0;
    int            exp_cnt = 0;   // consumed words since last reset
    logic [DW-1:0] exp_q[$];      // words offered and not yet consumed
    logic [DW-1:0] last_word = '0;

    // ---------------- driver tasks ----------------
    // Outputs are sampled and inputs driven 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = 1'b0; ready = 1'b0; err_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
        last_word = '0;
    endtask

    // Raise req with a word; wait for valid and check latency and data.
    task automatic offer(input logic [DW-1:0] data);
        int n;
        bus = data;
        req = 1'b1;
        exp_q.push_back(data);
        n = 0;
        while (!valid && n < TIMEOUT) begin
            step();
            n++;
        end
        total_cnt++;
        if (n !== NS + 1) $display("FAIL valid_latency: got %0d edges, want %0d", n, NS + 1);
        else pass_cnt++;
        total_cnt++;
        if ({sbus, sbus2} !== {exp_q[0], exp_q[0]})
            $display("FAIL capture_data: got %h/%h, want %h", sbus, sbus2, exp_q[0]);
        else pass_cnt++;
    endtask

    // Keep ready low for k cycles; valid and the word must hold steady.
    task automatic stall(input int k);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
            step();
            if (valid !== 1'b1 || sbus !== exp_q[0] || ack !== 1'b0) ok = 1'b0;
        end
        total_cnt++;
        if (!ok) $display("FAIL stall_hold: valid=%b bus=%h ack=%b, want valid=1 bus=%h ack=0",
                          valid, sbus, ack, exp_q[0]);
        else pass_cnt++;
    endtask

    // Pulse ready for one edge; expect ack up, valid down, counter up.
    task automatic consume();
        ready = 1'b1;
        step();
        ready = 1'b0;
        last_word = exp_q.pop_front();
        exp_cnt++;
        total_cnt++;
        if ({ack, valid, ack2, valid2} !== 4'b1010)
            $display("FAIL consume_hs: ack/valid=%b%b (w2 %b%b), want 10", ack, valid, ack2, valid2);
        else pass_cnt++;
        total_cnt++;
        if ({cnt, cnt2} !== {8'(exp_cnt), 2'(exp_cnt)})
            $display("FAIL xfer_cnt: got %0d/%0d, want %0d/%0d", cnt, cnt2, 8'(exp_cnt), 2'(exp_cnt));
        else pass_cnt++;
        total_cnt++;
        if (sbus !== last_word) $display("FAIL bus_after_consume: got %h, want %h", sbus, last_word);
        else pass_cnt++;
    endtask

    // Drop req; ack must fall NUM_STAGES+1 edges later with no new valid.
    task automatic release_req();
        int   n;
        logic saw_valid;
        req = 1'b0;
        n = 0;
        saw_valid = 1'b0;
        while (ack && n < TIMEOUT) begin
            step();
            n++;
            if (valid) saw_valid = 1'b1;
        end
        total_cnt++;
        if (n !== NS + 1 || saw_valid)
            $display("FAIL ack_release: got %0d edges (valid seen=%b), want %0d edges, no valid",
                     n, saw_valid, NS + 1);
        else pass_cnt++;
    endtask

    task automatic transfer(input logic [DW-1:0] data, input int delay);
        offer(data);
        if (delay > 0) stall(delay);
        consume();
        release_req();
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        apply_reset();
        total_cnt++;
        if ({ack, valid, perr, sbus, cnt} !== '0 || {ack2, valid2, perr2, sbus2, cnt2} !== '0)
            $display("FAIL reset_state: ack=%b valid=%b err=%b bus=%h cnt=%0d, want all 0",
                     ack, valid, perr, sbus, cnt);
        else pass_cnt++;
    endtask

    task automatic test_single();
        transfer(8'hA5, 0);
    endtask

    task automatic test_ready_stall();
        transfer(8'hA5, 10);
    endtask

    // Source drops req while the word is unconsumed. If clr_during is set,
    // err_clr is held high across the setting edge: the set must win, and
    // the held clear then takes effect on the following edge.
    task automatic test_proto_err(input logic clr_during);
        int   n;
        int   cnt_before;
        logic saw_ack;
        cnt_before = exp_cnt;
        offer(logic'($urandom_range(0, 1)) ? 8'($urandom_range(0, 255)) : 8'h5A);
        stall($urandom_range(1, 4));
        req = 1'b0;
        err_clr = clr_during;
        n = 0;
        saw_ack = 1'b0;
        while (valid && n < TIMEOUT) begin
            step();
            n++;
            if (ack) saw_ack = 1'b1;
        end
        void'(exp_q.pop_front());
        total_cnt++;
        if (n !== NS + 1) $display("FAIL proto_latency: got %0d edges, want %0d", n, NS + 1);
        else pass_cnt++;
        total_cnt++;
        if ({perr, perr2} !== 2'b11 || saw_ack || ack !== 1'b0)
            $display("FAIL proto_err_set: err=%b ack_seen=%b, want err=1 ack_seen=0", perr, saw_ack);
        else pass_cnt++;
        total_cnt++;
        if ({cnt, cnt2} !== {8'(cnt_before), 2'(cnt_before)})
            $display("FAIL proto_cnt: got %0d, want %0d", cnt, 8'(cnt_before));
        else pass_cnt++;
        // Error must stay sticky without a clear.
        if (!clr_during) begin
            repeat (3) step();
            total_cnt++;
            if (perr !== 1'b1) $display("FAIL proto_sticky: got %b, want 1", perr);
            else pass_cnt++;
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total_cnt++;
        if ({perr, perr2} !== 2'b00) $display("FAIL err_clr: got %b, want 0", perr);
        else pass_cnt++;
    endtask

    // req held high after ack must not yield a second word.
    task automatic test_hold_req();
        logic ok;
        offer(8'($urandom_range(0, 255)));
        consume();
        ok = 1'b1;
        repeat ($urandom_range(5, 15)) begin
            step();
            if (valid !== 1'b0 || ack !== 1'b1) ok = 1'b0;
        end
        total_cnt++;
        if (!ok) $display("FAIL hold_no_dup: valid=%b ack=%b, want valid=0 ack=1", valid, ack);
        else pass_cnt++;
        release_req();
        transfer(8'h3C, 0);
        total_cnt++;
        if (exp_q.size() !== 0 || last_word !== 8'h3C)
            $display("FAIL hold_new_word: last=%h pending=%0d, want 3c and 0 pending",
                     last_word, exp_q.size());
        else pass_cnt++;
    endtask

    // Five back-to-back transfers from reset: the CNT_W=2 counter must read
    // 1,2,3,0,1.
    task automatic test_back_to_back();
        logic [1:0] want_seq[5];
        logic [1:0] got_seq[5];
        want_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            transfer(8'($urandom_range(0, 255)), $urandom_range(0, 3));
            got_seq[i] = cnt2;
        end
        total_cnt++;
        if (got_seq !== want_seq)
            $display("FAIL wrap_seq: got %0d,%0d,%0d,%0d,%0d, want 1,2,3,0,1",
                     got_seq[0], got_seq[1], got_seq[2], got_seq[3], got_seq[4]);
        else pass_cnt++;
    endtask

    // Reset while HOLD (in_ack=0) or ACK (in_ack=1); a later transfer must
    // still complete.
    task automatic test_reset_mid(input logic in_ack);
        offer(8'($urandom_range(0, 255)));
        if (in_ack) consume();
        rst = 1'b1;
        req = 1'b0;
        step();
        total_cnt++;
        if ({ack, valid, perr, sbus, cnt} !== '0 || {ack2, valid2, cnt2} !== '0)
            $display("FAIL reset_mid_%0d: ack=%b valid=%b err=%b bus=%h cnt=%0d, want all 0",
                     in_ack, ack, valid, perr, sbus, cnt);
        else pass_cnt++;
        rst = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
        step();
        transfer(8'($urandom_range(0, 255)), $urandom_range(0, 4));
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            transfer(8'($urandom_range(0, 255)), $urandom_range(0, 6));
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_single();
        test_ready_stall();
        test_proto_err(1'b0);
        test_proto_err(1'b1);
        test_hold_req();
        test_back_to_back();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit (%0d/%0d checks passed)",
                 pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
